mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 135 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external 12x12 multiplier among NREQ requesters.
// Results are routed back per requester through a tag pipeline matching the multiplier latency.
module mult_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [12*NREQ-1:0]   req_a,
  input  logic [12*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [24*NREQ-1:0]   rsp_prod,
  output logic [11:0]          mul_a,
  output logic [11:0]          mul_b,
  input  logic [23:0]          mul_prod
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]    busy_q, busy_d;
  logic [NREQ-1:0]    eligible, hs;
  logic               gnt_found;
  logic [IdxW-1:0]    gnt_idx, cand;
  logic [LAT-1:0]     tag_vld_q, tag_vld_d;
  logic [IdxW-1:0]    tag_idx_q [LAT];
  logic [IdxW-1:0]    tag_idx_d [LAT];
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [24*NREQ-1:0] rsp_prod_q, rsp_prod_d;
  logic               cap_vld;
  logic [IdxW-1:0]    cap_idx;

  assign eligible = req_valid & ~busy_q;

  // First eligible index at or above ptr, wrapping; grant suppressed while in reset.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IdxW'((32'(ptr_q) + off) % NREQ);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found && reset) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign hs = req_valid & req_ready;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      mul_a = mul_a | (req_a[12*i +: 12] & {12{req_ready[i]}});
      mul_b = mul_b | (req_b[12*i +: 12] & {12{req_ready[i]}});
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|hs) begin
      ptr_d = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = |hs;
    for (int s = 0; s < LAT; s++) begin
      tag_idx_d[s] = '0;
    end
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  assign cap_vld = tag_vld_q[LAT-1];
  assign cap_idx = tag_idx_q[LAT-1];

  // busy covers issue through consumption, so a capture never lands on a held result.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_prod_d  = rsp_prod_q;
    busy_d      = busy_q;
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
        busy_d[i]      = 1'b0;
      end
      if (hs[i]) begin
        busy_d[i] = 1'b1;
      end
      if (cap_vld && (cap_idx == IdxW'(i))) begin
        rsp_valid_d[i]        = 1'b1;
        rsp_prod_d[24*i +: 24] = mul_prod;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_prod_q  <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_prod_q  <= rsp_prod_d;
      for (int s = 0; s < LAT; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_prod  = rsp_prod_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a 2-stage behavioural multiplier on the shared port.
module tb_mult_share_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [12*NREQ-1:0] req_a;
  logic [12*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [24*NREQ-1:0] rsp_prod;
  logic [11:0]       mul_a;
  logic [11:0]       mul_b;
  logic [23:0]       m1, m2;

  int total = 0;
  int bad   = 0;

  logic [23:0] prod_exp [4];
  logic [3:0]  e;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m1 <= 24'(mul_a) * 24'(mul_b);
    m2 <= m1;
  end

  mult_share_arbiter #(.NREQ(NREQ), .LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prod  (m2)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    prod_exp[0] = 24'd6;
    prod_exp[1] = 24'd77;
    prod_exp[2] = 24'd2000;
    prod_exp[3] = 24'd16769025;
    req_valid = '0;
    rsp_ready = '0;
    req_a = {12'd4095, 12'd100, 12'd7, 12'd2};
    req_b = {12'd4095, 12'd20, 12'd11, 12'd3};
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();

    // reset state, with requests pending to exercise gating
    req_valid = 4'hf;
    #1;
    check_eq("rst_req_ready", 96'(req_ready), 96'd0);
    check_eq("rst_mul_a", 96'(mul_a), 96'd0);
    check_eq("rst_mul_b", 96'(mul_b), 96'd0);
    check_eq("rst_rsp_valid", 96'(rsp_valid), 96'd0);
    check_eq("rst_rsp_prod", rsp_prod, 96'd0);

    tick();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 4'hf;

    // round robin from ptr=0
    for (int c = 0; c < 8; c++) begin
      tick();
      req_valid = (c < 4) ? 4'hf : 4'h0;
      #1;
      e = (c < 4) ? 4'(1 << c) : 4'h0;
      check_eq("rr_grant", 96'(req_ready), 96'(e));
      e = (c >= 3 && c < 7) ? 4'(1 << (c - 3)) : 4'h0;
      check_eq("rr_rsp_valid", 96'(rsp_valid), 96'(e));
      if (c >= 3 && c < 7) check_eq("rr_prod", 96'(rsp_prod[24*(c-3) +: 24]), 96'(prod_exp[c-3]));
      if (c == 6) check_eq("rr_prod0_held", 96'(rsp_prod[23:0]), 96'd6);
    end

    // single request 3*5
    req_a[11:0] = 12'd3;
    req_b[11:0] = 12'd5;
    tick();
    req_valid = 4'b0001;
    #1;
    check_eq("single_grant", 96'(req_ready), 96'h1);
    check_eq("single_mul_a", 96'(mul_a), 96'd3);
    check_eq("single_mul_b", 96'(mul_b), 96'd5);
    for (int s = 1; s <= 4; s++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("single_rsp_valid", 96'(rsp_valid), (s == 3) ? 96'h1 : 96'h0);
      if (s == 3) check_eq("single_prod", 96'(rsp_prod[23:0]), 96'd15);
    end
    req_a[11:0] = 12'd2;
    req_b[11:0] = 12'd3;

    // idle keeps ptr at 1
    for (int s = 0; s < 5; s++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("idle_ready", 96'(req_ready), 96'd0);
      check_eq("idle_mul_a", 96'(mul_a), 96'd0);
      check_eq("idle_mul_b", 96'(mul_b), 96'd0);
    end
    tick();
    req_valid = 4'hf;
    #1;
    check_eq("idle_ptr_held", 96'(req_ready), 96'h2);
    for (int d = 1; d <= 4; d++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("idle_rsp_valid", 96'(rsp_valid), (d == 3) ? 96'h2 : 96'h0);
      if (d == 3) check_eq("idle_prod", 96'(rsp_prod[47:24]), 96'd77);
    end

    // pointer wrap: grant 3, then 0 and 3 both eligible
    tick();
    req_valid = 4'b1000;
    #1;
    check_eq("wrap_grant3", 96'(req_ready), 96'h8);
    for (int w = 1; w <= 4; w++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("wrap_rsp3", 96'(rsp_valid), (w == 3) ? 96'h8 : 96'h0);
    end
    tick();
    req_valid = 4'b1001;
    #1;
    check_eq("wrap_grant0", 96'(req_ready), 96'h1);
    tick();
    #1;
    check_eq("wrap_grant3b", 96'(req_ready), 96'h8);
    for (int w = 7; w <= 10; w++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("wrap_drain", 96'(rsp_valid), (w == 8) ? 96'h1 : ((w == 9) ? 96'h8 : 96'h0));
    end

    // backpressure on requester 1
    rsp_ready = 4'b1101;
    tick();
    req_valid = 4'b0010;
    #1;
    check_eq("bp_grant", 96'(req_ready), 96'h2);
    for (int b = 1; b <= 12; b++) begin
      tick();
      #1;
      check_eq("bp_no_regrant", 96'(req_ready), 96'h0);
      check_eq("bp_rsp_valid", 96'(rsp_valid), (b >= 3) ? 96'h2 : 96'h0);
      if (b >= 3) check_eq("bp_prod_stable", 96'(rsp_prod[47:24]), 96'd77);
    end
    tick();
    rsp_ready = 4'hf;
    #1;
    check_eq("bp_same_cycle", 96'(req_ready), 96'h0);
    check_eq("bp_rsp_held", 96'(rsp_valid), 96'h2);
    tick();
    #1;
    check_eq("bp_rsp_clear", 96'(rsp_valid), 96'h0);
    check_eq("bp_regrant", 96'(req_ready), 96'h2);
    for (int b = 15; b <= 18; b++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("bp_drain", 96'(rsp_valid), (b == 17) ? 96'h2 : 96'h0);
    end

    // reset while requester 2 is in flight
    tick();
    req_valid = 4'b0100;
    #1;
    check_eq("mid_grant2", 96'(req_ready), 96'h4);
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ready", 96'(req_ready), 96'h0);
    check_eq("mid_rst_mul_a", 96'(mul_a), 96'h0);
    check_eq("mid_rst_rsp_valid", 96'(rsp_valid), 96'h0);
    check_eq("mid_rst_prod", rsp_prod, 96'h0);
    tick();
    reset = 1'b1;
    req_valid = '0;
    #1;
    check_eq("mid_no_rsp", 96'(rsp_valid), 96'h0);
    for (int r = 0; r < 3; r++) begin
      tick();
      #1;
      check_eq("mid_no_rsp", 96'(rsp_valid), 96'h0);
    end
    tick();
    req_valid = 4'b0101;
    #1;
    check_eq("mid_after_grant", 96'(req_ready), 96'h1);
    for (int r = 1; r <= 3; r++) begin
      tick();
      req_valid = '0;
      #1;
      check_eq("mid_after_rsp", 96'(rsp_valid), (r == 3) ? 96'h1 : 96'h0);
      if (r == 3) check_eq("mid_after_prod", 96'(rsp_prod[23:0]), 96'd6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
